// File: rtl/riskiv_pkg.sv
// Shared definitions for the RISK-IV execute stage: widths, opcodes,
// status-register bit positions and the registered result bundle.
package riskiv_pkg;

  localparam int WORD       = 16;
  localparam int OPSIZE     = 5;
  localparam int SREG_FLAGS = 4;

  // Opcode encodings (instr[15:11]); 17..31 are unused and behave as NOP.
  localparam logic [OPSIZE-1:0] OP_NOP  = 5'd0;
  localparam logic [OPSIZE-1:0] OP_LDI  = 5'd1;
  localparam logic [OPSIZE-1:0] OP_MOV  = 5'd2;
  localparam logic [OPSIZE-1:0] OP_ADD  = 5'd3;
  localparam logic [OPSIZE-1:0] OP_SUB  = 5'd4;
  localparam logic [OPSIZE-1:0] OP_AND  = 5'd5;
  localparam logic [OPSIZE-1:0] OP_OR   = 5'd6;
  localparam logic [OPSIZE-1:0] OP_XOR  = 5'd7;
  localparam logic [OPSIZE-1:0] OP_NOT  = 5'd8;
  localparam logic [OPSIZE-1:0] OP_INC  = 5'd9;
  localparam logic [OPSIZE-1:0] OP_DEC  = 5'd10;
  localparam logic [OPSIZE-1:0] OP_CMP  = 5'd11;
  localparam logic [OPSIZE-1:0] OP_LD   = 5'd12;
  localparam logic [OPSIZE-1:0] OP_ST   = 5'd13;
  localparam logic [OPSIZE-1:0] OP_JMP  = 5'd14;
  localparam logic [OPSIZE-1:0] OP_RJMP = 5'd15;
  localparam logic [OPSIZE-1:0] OP_BREQ = 5'd16;

  // Status register bit indices.
  localparam int SREG_Z = 0;
  localparam int SREG_N = 1;
  localparam int SREG_C = 2;
  localparam int SREG_V = 3;

  // Everything the write-back stages consume, registered as one bundle.
  typedef struct packed {
    logic [WORD-1:0] sreg;
    logic            flag_update;
    logic [WORD-1:0] reg_write_val;
    logic [2:0]      reg_write_code;
    logic            reg_wb;
    logic [WORD-1:0] mem_write_val;
    logic [WORD-1:0] mem_write_addr;
    logic            mem_wb;
    logic [WORD-1:0] pc_jump_loc;
    logic [WORD-1:0] pc_jump_inc;
    logic            jump;
    logic            rjump;
  } exec_out_t;

  // Opcodes that produce new status flags (ADD through CMP).
  function automatic logic is_flag_op(input logic [OPSIZE-1:0] op);
    return (op >= OP_ADD) && (op <= OP_CMP);
  endfunction

endpackage

// File: rtl/execute_unit_alu_core.sv
// Combinational ALU: computes the result of an arithmetic/logic opcode
// on two operands together with the Z/N/C/V flags it produces.
module alu_core
  import riskiv_pkg::*;
(
  input  logic [OPSIZE-1:0]     op,
  input  logic [WORD-1:0]       a,
  input  logic [WORD-1:0]       b,
  output logic [WORD-1:0]       result,
  output logic [SREG_FLAGS-1:0] flags
);

  localparam int MSB = WORD - 1;

  logic [WORD:0] ext;
  logic          carry;
  logic          ovf;

  // Operation select; C is carry for ADD and borrow for SUB/CMP/DEC.
  always_comb begin
    ext    = '0;
    result = a;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        ext    = {1'b0, a} + {1'b0, b};
        result = ext[WORD-1:0];
        carry  = ext[WORD];
        ovf    = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        ext    = {1'b0, a} - {1'b0, b};
        result = ext[WORD-1:0];
        carry  = ext[WORD];
        ovf    = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_INC: begin
        result = a + WORD'(1);
        ovf    = result[MSB] & ~a[MSB];
      end
      OP_DEC: begin
        ext    = {1'b0, a} - {{WORD{1'b0}}, 1'b1};
        result = ext[WORD-1:0];
        carry  = ext[WORD];
        ovf    = a[MSB] & ~result[MSB];
      end
      default: result = a;
    endcase
  end

  // Flag vector in status-register bit order.
  always_comb begin
    flags         = '0;
    flags[SREG_Z] = (result == '0);
    flags[SREG_N] = result[MSB];
    flags[SREG_C] = carry;
    flags[SREG_V] = ovf;
  end

endmodule

// File: rtl/execute_unit.sv
// Decode/execute stage of the RISK-IV CPU. Decodes the opcode, uses the
// ALU for arithmetic/logic, and registers the write-back bundle on each
// execute trigger. Outputs hold between triggers.
module execute_unit
  import riskiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              dne_tr,
  input  logic [OPSIZE-1:0] opcode,
  input  logic [2:0]        reg1_code,
  input  logic [2:0]        reg2_code,
  input  logic [WORD-1:0]   imm,
  input  logic [WORD-1:0]   SREG_in,
  input  logic [WORD-1:0]   mem_read_data,
  input  logic [WORD-1:0]   reg1_input_data,
  input  logic [WORD-1:0]   reg2_input_data,
  output logic [WORD-1:0]   SREG_out,
  output logic              flag_update,
  output logic [WORD-1:0]   reg_write_val,
  output logic [2:0]        reg_write_code,
  output logic              reg_wb,
  output logic [WORD-1:0]   mem_write_val,
  output logic [WORD-1:0]   mem_write_addr,
  output logic              mem_wb,
  output logic [WORD-1:0]   PC_jump_loc,
  output logic [WORD-1:0]   PC_jump_inc,
  output logic              jump,
  output logic              rjump
);

  logic [WORD-1:0]       alu_result;
  logic [SREG_FLAGS-1:0] alu_flags;
  exec_out_t             out_reg;
  exec_out_t             out_next;

  // Operand values already arrive from the register file, so the source
  // register number itself is not needed here.
  logic unused_reg2_code;
  assign unused_reg2_code = ^reg2_code;

  alu_core u_alu (
    .op     (opcode),
    .a      (reg1_input_data),
    .b      (reg2_input_data),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // Decode: start from a cleared bundle, then set only what the opcode needs.
  always_comb begin
    out_next                = '0;
    out_next.sreg           = SREG_in;
    out_next.reg_write_code = reg1_code;
    if (is_flag_op(opcode)) begin
      out_next.sreg        = {SREG_in[WORD-1:SREG_FLAGS], alu_flags};
      out_next.flag_update = 1'b1;
    end
    case (opcode)
      OP_LDI: begin
        out_next.reg_wb        = 1'b1;
        out_next.reg_write_val = imm;
      end
      OP_MOV: begin
        out_next.reg_wb        = 1'b1;
        out_next.reg_write_val = reg2_input_data;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_INC, OP_DEC: begin
        out_next.reg_wb        = 1'b1;
        out_next.reg_write_val = alu_result;
      end
      OP_LD: begin
        out_next.reg_wb        = 1'b1;
        out_next.reg_write_val = mem_read_data;
      end
      OP_ST: begin
        out_next.mem_wb         = 1'b1;
        out_next.mem_write_val  = reg1_input_data;
        out_next.mem_write_addr = imm;
      end
      OP_JMP: begin
        out_next.jump        = 1'b1;
        out_next.pc_jump_loc = imm;
      end
      OP_RJMP: begin
        out_next.rjump       = 1'b1;
        out_next.pc_jump_inc = imm;
      end
      OP_BREQ: begin
        if (SREG_in[SREG_Z]) begin
          out_next.rjump       = 1'b1;
          out_next.pc_jump_inc = imm;
        end
      end
      default: ;
    endcase
  end

  // Output register: reset wins over the trigger; otherwise load on dne_tr.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg <= '0;
    end else if (dne_tr) begin
      out_reg <= out_next;
    end
  end

  assign SREG_out       = out_reg.sreg;
  assign flag_update    = out_reg.flag_update;
  assign reg_write_val  = out_reg.reg_write_val;
  assign reg_write_code = out_reg.reg_write_code;
  assign reg_wb         = out_reg.reg_wb;
  assign mem_write_val  = out_reg.mem_write_val;
  assign mem_write_addr = out_reg.mem_write_addr;
  assign mem_wb         = out_reg.mem_wb;
  assign PC_jump_loc    = out_reg.pc_jump_loc;
  assign PC_jump_inc    = out_reg.pc_jump_inc;
  assign jump           = out_reg.jump;
  assign rjump          = out_reg.rjump;

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit with hand-computed expected values.
module tb_execute_unit;

  logic        clk;
  logic        rst;
  logic        dne_tr;
  logic [4:0]  opcode;
  logic [2:0]  reg1_code;
  logic [2:0]  reg2_code;
  logic [15:0] imm;
  logic [15:0] SREG_in;
  logic [15:0] mem_read_data;
  logic [15:0] reg1_input_data;
  logic [15:0] reg2_input_data;
  logic [15:0] SREG_out;
  logic        flag_update;
  logic [15:0] reg_write_val;
  logic [2:0]  reg_write_code;
  logic        reg_wb;
  logic [15:0] mem_write_val;
  logic [15:0] mem_write_addr;
  logic        mem_wb;
  logic [15:0] PC_jump_loc;
  logic [15:0] PC_jump_inc;
  logic        jump;
  logic        rjump;

  int checks = 0;
  int errors = 0;

  execute_unit dut (
    .clk             (clk),
    .rst             (rst),
    .dne_tr          (dne_tr),
    .opcode          (opcode),
    .reg1_code       (reg1_code),
    .reg2_code       (reg2_code),
    .imm             (imm),
    .SREG_in         (SREG_in),
    .mem_read_data   (mem_read_data),
    .reg1_input_data (reg1_input_data),
    .reg2_input_data (reg2_input_data),
    .SREG_out        (SREG_out),
    .flag_update     (flag_update),
    .reg_write_val   (reg_write_val),
    .reg_write_code  (reg_write_code),
    .reg_wb          (reg_wb),
    .mem_write_val   (mem_write_val),
    .mem_write_addr  (mem_write_addr),
    .mem_wb          (mem_wb),
    .PC_jump_loc     (PC_jump_loc),
    .PC_jump_inc     (PC_jump_inc),
    .jump            (jump),
    .rjump           (rjump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one instruction and pulse dne_tr; returns 1 ns after the capturing edge.
  task automatic exec_op(input logic [4:0] op, input logic [2:0] r1c, input logic [2:0] r2c,
                         input logic [15:0] immv, input logic [15:0] sreg,
                         input logic [15:0] mem, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    opcode          = op;
    reg1_code       = r1c;
    reg2_code       = r2c;
    imm             = immv;
    SREG_in         = sreg;
    mem_read_data   = mem;
    reg1_input_data = a;
    reg2_input_data = b;
    dne_tr          = 1'b1;
    @(posedge clk);
    #1;
    dne_tr = 1'b0;
    $display("op=%0d r1=%0d imm=%h sreg=%h a=%h b=%h -> val=%h wb=%b sreg_out=%h fu=%b mem_wb=%b j=%b rj=%b",
             op, r1c, immv, sreg, a, b, reg_write_val, reg_wb, SREG_out, flag_update, mem_wb, jump, rjump);
  endtask

  initial begin
    // Reset for two cycles with a live LDI trigger that must be ignored.
    rst = 1'b1; dne_tr = 1'b1; opcode = 5'd1; reg1_code = 3'd3; reg2_code = 3'd0;
    imm = 16'h1234; SREG_in = 16'hFFFF; mem_read_data = 16'h0; reg1_input_data = 16'h0;
    reg2_input_data = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_reg_wb",      {15'b0, reg_wb},        16'h0);
    check("rst_val",         reg_write_val,          16'h0);
    check("rst_code",        {13'b0, reg_write_code},16'h0);
    check("rst_sreg",        SREG_out,               16'h0);
    check("rst_enables",     {12'b0, flag_update, mem_wb, jump, rjump}, 16'h0);
    check("rst_mem_addr",    mem_write_addr,         16'h0);
    @(negedge clk);
    rst = 1'b0; dne_tr = 1'b0;

    // LDI r3, 0x1234
    exec_op(5'd1, 3'd3, 3'd0, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h0);
    check("ldi_wb",   {15'b0, reg_wb},          16'h1);
    check("ldi_code", {13'b0, reg_write_code},  16'h3);
    check("ldi_val",  reg_write_val,            16'h1234);
    check("ldi_mem_wb", {15'b0, mem_wb},        16'h0);
    check("ldi_fu",   {15'b0, flag_update},     16'h0);

    // ADD 0x7FFF + 1 -> 0x8000, N and V
    exec_op(5'd3, 3'd1, 3'd2, 16'h0, 16'h0, 16'h0, 16'h7FFF, 16'h0001);
    check("add_val",  reg_write_val,            16'h8000);
    check("add_fu",   {15'b0, flag_update},     16'h1);
    check("add_sreg", SREG_out,                 16'h000A);

    // SUB 5 - 5 -> 0, Z only
    exec_op(5'd4, 3'd1, 3'd2, 16'h0, 16'h0, 16'h0, 16'h0005, 16'h0005);
    check("sub_val",  reg_write_val,            16'h0000);
    check("sub_sreg", SREG_out,                 16'h0001);

    // CMP 3 - 5 -> 0xFFFE: N and borrow, no register write
    exec_op(5'd11, 3'd1, 3'd2, 16'h0, 16'h0, 16'h0, 16'h0003, 16'h0005);
    check("cmp_sreg", SREG_out,                 16'h0006);
    check("cmp_wb",   {15'b0, reg_wb},          16'h0);
    check("cmp_fu",   {15'b0, flag_update},     16'h1);

    // AND keeps upper SREG bits, clears C/V, result nonzero
    exec_op(5'd5, 3'd4, 3'd2, 16'h0, 16'hF00F, 16'h0, 16'h0F0F, 16'h00FF);
    check("and_val",  reg_write_val,            16'h000F);
    check("and_sreg", SREG_out,                 16'hF000);

    // DEC 0 -> 0xFFFF with N and borrow
    exec_op(5'd10, 3'd5, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0000, 16'h0);
    check("dec_val",  reg_write_val,            16'hFFFF);
    check("dec_sreg", SREG_out,                 16'h0006);

    // INC 0x7FFF -> 0x8000 with N and V
    exec_op(5'd9, 3'd5, 3'd0, 16'h0, 16'h0, 16'h0, 16'h7FFF, 16'h0);
    check("inc_val",  reg_write_val,            16'h8000);
    check("inc_sreg", SREG_out,                 16'h000A);

    // ST 0xBEEF -> mem[0x0040]
    exec_op(5'd13, 3'd2, 3'd0, 16'h0040, 16'h0, 16'h0, 16'hBEEF, 16'h0);
    check("st_mem_wb", {15'b0, mem_wb},         16'h1);
    check("st_addr",   mem_write_addr,          16'h0040);
    check("st_val",    mem_write_val,           16'hBEEF);
    check("st_reg_wb", {15'b0, reg_wb},         16'h0);
    check("st_sreg",   SREG_out,                16'h0000);

    // LD r6 <- 0x00AA
    exec_op(5'd12, 3'd6, 3'd0, 16'h0040, 16'h0, 16'h00AA, 16'h0, 16'h0);
    check("ld_wb",   {15'b0, reg_wb},           16'h1);
    check("ld_val",  reg_write_val,             16'h00AA);
    check("ld_code", {13'b0, reg_write_code},   16'h6);

    // Change inputs without a trigger: outputs must hold the LD result
    @(negedge clk);
    opcode = 5'd13; reg1_code = 3'd1; imm = 16'h5555; mem_read_data = 16'h1111;
    reg1_input_data = 16'h2222;
    repeat (2) @(posedge clk);
    #1;
    check("hold_val",    reg_write_val,          16'h00AA);
    check("hold_wb",     {15'b0, reg_wb},        16'h1);
    check("hold_mem_wb", {15'b0, mem_wb},        16'h0);

    // JMP 7
    exec_op(5'd14, 3'd0, 3'd0, 16'h0007, 16'h0, 16'h0, 16'h0, 16'h0);
    check("jmp_jump", {15'b0, jump},             16'h1);
    check("jmp_loc",  PC_jump_loc,               16'h0007);
    check("jmp_wb",   {15'b0, reg_wb},           16'h0);

    // BREQ -2 taken when Z set
    exec_op(5'd16, 3'd0, 3'd0, 16'hFFFE, 16'h0001, 16'h0, 16'h0, 16'h0);
    check("breq_t_rjump", {15'b0, rjump},        16'h1);
    check("breq_t_inc",   PC_jump_inc,           16'hFFFE);
    check("breq_t_jump",  {15'b0, jump},         16'h0);
    check("breq_t_sreg",  SREG_out,              16'h0001);

    // BREQ not taken when Z clear
    exec_op(5'd16, 3'd0, 3'd0, 16'hFFFE, 16'h0000, 16'h0, 16'h0, 16'h0);
    check("breq_n_rjump", {15'b0, rjump},        16'h0);

    // JMP again, then unused opcode 31 must clear every enable
    exec_op(5'd14, 3'd0, 3'd0, 16'h0009, 16'h0, 16'h0, 16'h0, 16'h0);
    exec_op(5'd31, 3'd2, 3'd1, 16'h0009, 16'h00F3, 16'h0, 16'h1234, 16'h5678);
    check("op31_enables", {11'b0, flag_update, reg_wb, mem_wb, jump, rjump}, 16'h0);
    check("op31_sreg",    SREG_out,              16'h00F3);

    // Reset after activity returns outputs to zero
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst2_sreg", SREG_out,                 16'h0);
    check("rst2_code", {13'b0, reg_write_code},  16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
